// File: rtl/de0qsys_pio_pkg.sv
// de0qsys_pio_pkg
// Shared definitions for the de0qsys output PIO and its pulse timer:
//   - word addresses of the four slave registers
//   - state encoding of the auto-clear pulse engine
package de0qsys_pio_pkg;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_SET   = 2'd1;
  localparam logic [1:0] ADDR_CLEAR = 2'd2;
  localparam logic [1:0] ADDR_PLEN  = 2'd3;

  typedef enum logic {
    PS_IDLE = 1'b0,
    PS_RUN  = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/de0qsys_pulse_timer.sv
// de0qsys_pulse_timer
// Down-counter plus pulse mask for the auto-clearing strobe feature of
// de0qsys_pio_out. A SET write with a non-zero length (re)arms the timer.
// When the count runs out, expire_o tells the owner to clear the pmask bits.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   set_i          SET write this cycle (start or restart)
//   set_mask_i     bits written by SET
//   plen_i         current pulse length (0 = no pulse)
//   abort_i        DATA write this cycle; kills any running pulse
//   clr_i          CLEAR write this cycle
//   clr_mask_i     bits written by CLEAR
//   expire_o       pulse ends on this edge; owner clears pmask_o bits
//   pmask_o        bits owned by the running pulse
//   busy_o         countdown active
module de0qsys_pulse_timer
  import de0qsys_pio_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int PLEN_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              set_i,
  input  logic [WIDTH-1:0]  set_mask_i,
  input  logic [PLEN_W-1:0] plen_i,
  input  logic              abort_i,
  input  logic              clr_i,
  input  logic [WIDTH-1:0]  clr_mask_i,
  output logic              expire_o,
  output logic [WIDTH-1:0]  pmask_o,
  output logic              busy_o
);

  pulse_state_e      state_q, state_d;
  logic [PLEN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  pmask_q, pmask_d;
  logic [WIDTH-1:0]  mask_clr;
  logic              plen_nz;

  assign plen_nz = |plen_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pmask_d  = pmask_q;
    expire_o = 1'b0;
    mask_clr = pmask_q & ~clr_mask_i;
    unique case (state_q)
      PS_IDLE: begin
        if (set_i && plen_nz && (|set_mask_i)) begin
          state_d = PS_RUN;
          pmask_d = set_mask_i;
          cnt_d   = plen_i;
        end
      end
      PS_RUN: begin
        if (abort_i) begin
          state_d = PS_IDLE;
          pmask_d = '0;
          cnt_d   = '0;
        end else if (set_i && plen_nz) begin
          // Restart takes priority over an expiry on the same edge.
          pmask_d = pmask_q | set_mask_i;
          cnt_d   = plen_i;
        end else if (cnt_q == PLEN_W'(1)) begin
          // A SET with zero length while running is a plain OR and lets
          // the pulse continue to expire normally.
          expire_o = 1'b1;
          state_d  = PS_IDLE;
          pmask_d  = '0;
          cnt_d    = '0;
        end else begin
          if (clr_i) pmask_d = mask_clr;
          if (clr_i && (mask_clr == '0)) begin
            state_d = PS_IDLE;
            cnt_d   = '0;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PLEN_W'(1);
          end
        end
      end
      default: begin
        state_d = PS_IDLE;
        pmask_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PS_IDLE;
      cnt_q   <= '0;
      pmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pmask_q <= pmask_d;
    end
  end

  assign pmask_o = pmask_q;
  assign busy_o  = (state_q == PS_RUN);

endmodule

// File: rtl/de0qsys_pio_out.sv
// de0qsys_pio_out
// Avalon-MM output PIO with atomic set/clear and optional timed auto-clear
// pulses. Registers: 0 DATA (R/W), 1 SET (W, reads 0), 2 CLEAR (W, reads 0),
// 3 PLEN (R/W pulse length in clk cycles). Read latency is one cycle.
// Build option: define DE0QSYS_PIO_OUT_PULSE_EN to build the pulse engine;
// without it PLEN reads 0, SET is a plain OR and pulse_busy is tied 0.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   chipselect     slave select; write = chipselect & ~write_n
//   address        word register index
//   write_n        active-low write strobe
//   writedata      write data (bits above WIDTH ignored)
//   readdata       registered read data, zero-extended
//   out_port       output pins, straight from DATA
//   pulse_busy     pulse countdown running
module de0qsys_pio_out
  import de0qsys_pio_pkg::*;
#(
  parameter int          WIDTH       = 4,
  parameter logic [31:0] RESET_VALUE = '0,
  parameter int          PLEN_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             pulse_busy
);

  logic             wr;
  logic             wr_data, wr_set, wr_clr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             expire;
  logic [WIDTH-1:0] pmask;
  logic [PLEN_W-1:0] plen_rd;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign wr_data   = wr && (address == ADDR_DATA);
  assign wr_set    = wr && (address == ADDR_SET);
  assign wr_clr    = wr && (address == ADDR_CLEAR);
  assign unused_wd = ^writedata;

`ifdef DE0QSYS_PIO_OUT_PULSE_EN
  logic              wr_plen;
  logic [PLEN_W-1:0] plen_q, plen_d;

  assign wr_plen = wr && (address == ADDR_PLEN);
  assign plen_d  = wr_plen ? writedata[PLEN_W-1:0] : plen_q;
  assign plen_rd = plen_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) plen_q <= '0;
    else          plen_q <= plen_d;
  end

  de0qsys_pulse_timer #(
    .WIDTH  (WIDTH),
    .PLEN_W (PLEN_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_i      (wr_set),
    .set_mask_i (wd),
    .plen_i     (plen_q),
    .abort_i    (wr_data),
    .clr_i      (wr_clr),
    .clr_mask_i (wd),
    .expire_o   (expire),
    .pmask_o    (pmask),
    .busy_o     (pulse_busy)
  );
`else
  assign expire     = 1'b0;
  assign pmask      = '0;
  assign plen_rd    = '0;
  assign pulse_busy = 1'b0;
`endif

  always_comb begin
    data_d = data_q;
    if (wr_data)     data_d = wd;
    else if (wr_set) data_d = data_q | wd;
    else if (wr_clr) data_d = data_q & ~wd;
    // Expiry stacks on top of a coincident CLEAR or PLEN write.
    if (expire) data_d = data_d & ~pmask;
  end

  // Read mux is sampled every cycle, independent of chipselect.
  always_comb begin
    readdata_d = '0;
    unique case (address)
      ADDR_DATA: readdata_d = 32'(data_q);
      ADDR_PLEN: readdata_d = 32'(plen_rd);
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE[WIDTH-1:0];
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      readdata_q <= readdata_d;
    end
  end

  assign out_port = data_q;
  assign readdata = readdata_q;

endmodule

// File: tb/tb_de0qsys_pio_out.sv
// tb_de0qsys_pio_out
// Directed sequences followed by random bus traffic, each cycle checked
// against a behavioural model of the PIO. Pulses are modelled as a
// deadline (edge number at which the owned bits drop) rather than a counter.
// Works with and without DE0QSYS_PIO_OUT_PULSE_EN.
module tb_de0qsys_pio_out;

  localparam int          WIDTH  = 4;
  localparam logic [31:0] RV     = 32'hA;
  localparam int          PLEN_W = 16;
  localparam logic [31:0] MASK   = 32'hF;
`ifdef DE0QSYS_PIO_OUT_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic             chipselect;
  logic [1:0]       address;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;
  logic             pulse_busy;

  de0qsys_pio_out #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RV),
    .PLEN_W      (PLEN_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .pulse_busy (pulse_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_data, m_pmask, m_rd, m_plen;
  bit          m_busy;
  longint      m_edge, m_dead;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data  = RV & MASK;
    m_pmask = '0;
    m_rd    = '0;
    m_plen  = '0;
    m_busy  = 1'b0;
    m_edge  = 0;
    m_dead  = 0;
  endtask

  // Advance the model by one clock edge with the given bus inputs.
  task automatic model_edge(input logic cs, input logic wn, input logic [1:0] a,
                            input logic [31:0] wdat);
    logic        w;
    logic [31:0] wd;
    w  = cs & ~wn;
    wd = wdat & MASK;
    m_edge++;
    m_rd = (a == 2'd0) ? m_data : (a == 2'd3) ? m_plen : 32'd0;
    if (w) begin
      case (a)
        2'd0: begin
          m_data  = wd;
          m_busy  = 1'b0;
          m_pmask = '0;
        end
        2'd1: begin
          m_data = m_data | wd;
          if (PULSE && m_plen != 0) begin
            if (m_busy) begin
              m_pmask = m_pmask | wd;
              m_dead  = m_edge + longint'(m_plen);
            end else if (wd != 0) begin
              m_busy  = 1'b1;
              m_pmask = wd;
              m_dead  = m_edge + longint'(m_plen);
            end
          end
        end
        2'd2: begin
          m_data  = m_data & ~wd;
          m_pmask = m_pmask & ~wd;
        end
        default: if (PULSE) m_plen = wdat & 32'hFFFF;
      endcase
    end
    if (m_busy && m_edge == m_dead) begin
      m_data  = m_data & ~m_pmask;
      m_busy  = 1'b0;
      m_pmask = '0;
    end
    if (m_busy && m_pmask == 0) m_busy = 1'b0;
  endtask

  task automatic step(input logic cs, input logic wn, input logic [1:0] a,
                      input logic [31:0] wdat);
    @(negedge clk);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wdat;
    model_edge(cs, wn, a, wdat);
    @(posedge clk);
    #1;
    check("out_port", 32'(out_port), m_data);
    check("pulse_busy", 32'(pulse_busy), 32'(m_busy));
    check("readdata", readdata, m_rd);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    step(1'b1, 1'b1, a, $urandom);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 2'($urandom_range(0, 3)), $urandom);
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    model_reset();
    #12;
    check("rst_out_port", 32'(out_port), 32'hA);
    check("rst_readdata", readdata, 32'h0);
    check("rst_busy", 32'(pulse_busy), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    rd(2'd0);                                   // readdata = 0000000A
    check("rd_data_after_reset", readdata, 32'h0000000A);
    wr(2'd0, 32'h5); wr(2'd1, 32'h8); wr(2'd2, 32'h1);
    check("set_clear_seq", 32'(out_port), 32'hC);
    rd(2'd1); rd(2'd2);

    // Basic 3-cycle pulse
    wr(2'd3, 32'd3); wr(2'd0, 32'h0); wr(2'd1, 32'h2);
    repeat (5) idle();
    // Mask OR + restart
    wr(2'd3, 32'd4); wr(2'd1, 32'h1); idle(); wr(2'd1, 32'h4);
    repeat (6) idle();
    // Abort by DATA write
    wr(2'd3, 32'd5); wr(2'd1, 32'h3); idle(); wr(2'd0, 32'h8);
    repeat (3) idle();
    // Shortest pulse
    wr(2'd3, 32'd1); wr(2'd1, 32'h1); repeat (2) idle();
    // Expiry coinciding with CLEAR
    wr(2'd3, 32'd2); wr(2'd0, 32'h4); wr(2'd1, 32'h3); idle(); wr(2'd2, 32'h4);
    idle();
    // CLEAR empties the mask
    wr(2'd3, 32'd6); wr(2'd1, 32'h2); wr(2'd2, 32'h2); repeat (2) idle();

    // Asynchronous reset in the middle of a pulse
    wr(2'd3, 32'd6); wr(2'd1, 32'h5); idle();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_out_port", 32'(out_port), m_data);
    check("async_rst_busy", 32'(pulse_busy), 32'(m_busy));
    check("async_rst_readdata", readdata, m_rd);
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd3);

    // Long PLEN then SET
    wr(2'd3, 32'd7); wr(2'd1, 32'h1); repeat (10) idle(); rd(2'd3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic        cs, wn;
      logic [1:0]  a;
      logic [31:0] d;
      cs = ($urandom_range(0, 7) != 0);
      wn = ($urandom_range(0, 2) == 0);
      a  = 2'($urandom_range(0, 3));
      d  = (a == 2'd3) ? 32'($urandom_range(0, 6)) : $urandom;
      step(cs, wn, a, d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
